// File: rtl/reset_sequencer.sv
// Staged reset release: synchronises the raw reset, waits out PLL settling, then releases
// the downstream resets one by one. Also handles the firmware soft-reset handshake and a 1 us tick.
module reset_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 1080000,
  parameter int unsigned N_STAGES        = 3,
  parameter int unsigned STAGE_GAP       = 1024,
  parameter int unsigned SOFT_MIN_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 108
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                soft_req,
  output logic                soft_ack,
  output logic [N_STAGES-1:0] rst_n_out,
  output logic                ready,
  output logic                tick_us,
  output logic [2:0]          state
);

  localparam int unsigned MaxA   = (SETTLE_CYCLES > STAGE_GAP) ? SETTLE_CYCLES : STAGE_GAP;
  localparam int unsigned MaxB   = (SOFT_MIN_CYCLES > TICK_DIV) ? SOFT_MIN_CYCLES : TICK_DIV;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;
  localparam int unsigned IdxW   = $clog2(N_STAGES + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(STAGE_GAP - 1);
  localparam logic [CntW-1:0] SoftLast   = CntW'(SOFT_MIN_CYCLES - 1);
  localparam logic [CntW-1:0] TickLast   = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StHold   = 3'd0,
    StSettle = 3'd1,
    StStage  = 3'd2,
    StRun    = 3'd3,
    StSoft   = 3'd4
  } state_e;

  logic [1:0]          sync_q;
  logic                rel;
  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic                ready_q, ready_d;
  logic                tick_q, tick_d;
  logic                ack_q, ack_d;

  // Only this pair sees reset_n deassert; everything else waits for rel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rel = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      StHold: begin
        if (rel) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          state_d  = StStage;
          cnt_d    = '0;
          idx_d    = IdxW'(1);
          rst_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStage: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == IdxW'(N_STAGES)) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            for (int k = 0; k < N_STAGES; k++) begin
              if (idx_q == IdxW'(k)) rst_d[k] = 1'b1;
            end
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        // A soft request pre-empts a tick landing on the same edge.
        if (soft_req) begin
          state_d = StSoft;
          cnt_d   = '0;
          rst_d   = '0;
          ready_d = 1'b0;
          ack_d   = 1'b1;
        end else if (cnt_q == TickLast) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSoft: begin
        // Counter saturates at the minimum hold; exit then waits for soft_req to drop.
        if (cnt_q == SoftLast) begin
          if (!soft_req) begin
            state_d = StStage;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_n_out = rst_q;
  assign ready     = ready_q;
  assign tick_us   = tick_q;
  assign soft_ack  = ack_q;
  assign state     = state_q;

endmodule
